// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - binary-to-BCD controller for the 8-digit seven-segment path
//
// Converts an unsigned binary value, accepted over a valid/ready handshake,
// into eight registered BCD digits using a double-dabble (shift-add-3)
// sequence of BIN_W cycles. It also produces a registered blank mask for the
// downstream BCD->segment decoder.
//
// Ports:
//   clock        in   1      clock, rising edge
//   reset_L      in   1      asynchronous active-low reset
//   in_value     in   BIN_W  unsigned binary value to display
//   in_valid     in   1      in_value is valid
//   in_ready     out  1      controller accepts a value this cycle
//   lz_blank_en  in   1      blank leading zeros (sampled on acceptance)
//   clear        in   1      blank the whole display (acted on in IDLE only)
//   busy         out  1      conversion in progress
//   done         out  1      one-cycle pulse when new digits/blank take effect
//   BCD7..BCD0   out  4 each registered BCD digits, BCD7 most significant
//   blank        out  8      registered blank mask, bit i blanks digit i

module seg_display_ctrl #(
    parameter int BIN_W = 26
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [BIN_W-1:0] in_value,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             lz_blank_en,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [3:0]       BCD7,
    output logic [3:0]       BCD6,
    output logic [3:0]       BCD5,
    output logic [3:0]       BCD4,
    output logic [3:0]       BCD3,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD0,
    output logic [7:0]       blank
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [BIN_W-1:0] shreg;
    logic [31:0]      acc;
    logic [31:0]      acc_adj;
    logic [CNT_W-1:0] cnt;
    logic             lz_q;
    logic             xfer;
    logic             last_shift;
    logic [7:0]       lz_mask;
    logic             all_zero;

    assign xfer       = in_valid & in_ready;
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    // State register
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer)       state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = UPDATE;
            UPDATE:                  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Output logic. clear steals in_ready so it always wins over a pending value.
    always_comb begin
        in_ready = (state == IDLE) & ~clear;
        busy     = (state != IDLE);
    end

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift, so
    // it carries correctly into the next decade once doubled.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while every digit seen
    // so far is zero. Digit 0 is never blanked so a value of 0 shows "0".
    always_comb begin
        lz_mask  = 8'h00;
        all_zero = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            all_zero   = all_zero & (acc[i*4 +: 4] == 4'd0);
            lz_mask[i] = all_zero;
        end
    end

    // Datapath and registered outputs. Digits only change in UPDATE, so a
    // reset in the middle of SHIFT can never expose a partial result.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            lz_q  <= 1'b0;
            done  <= 1'b0;
            BCD7  <= 4'd0;
            BCD6  <= 4'd0;
            BCD5  <= 4'd0;
            BCD4  <= 4'd0;
            BCD3  <= 4'd0;
            BCD2  <= 4'd0;
            BCD1  <= 4'd0;
            BCD0  <= 4'd0;
            blank <= 8'hFF;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        shreg <= in_value;
                        lz_q  <= lz_blank_en;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (clear) begin
                        blank <= 8'hFF;
                    end
                end
                SHIFT: begin
                    acc   <= {acc_adj[30:0], shreg[BIN_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                UPDATE: begin
                    BCD7  <= acc[31:28];
                    BCD6  <= acc[27:24];
                    BCD5  <= acc[23:20];
                    BCD4  <= acc[19:16];
                    BCD3  <= acc[15:12];
                    BCD2  <= acc[11:8];
                    BCD1  <= acc[7:4];
                    BCD0  <= acc[3:0];
                    blank <= lz_q ? lz_mask : 8'h00;
                    done  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
